// File: rtl/uexe_if.sv
// ID/EX -> EX/MEM bundle for the execute stage: pipeline inputs, write-back forwarding source,
// global stall/flush, registered EX/MEM outputs and the multiply stall request.
interface uexe_if;
  logic [3:0]  idexaluop;
  logic        idexalusrc;
  logic        idexbranch;
  logic        idexmemwrite;
  logic        idexregwrite;
  logic        idexmemtoreg;
  logic [31:0] idexr1_dout;
  logic [31:0] idexr2_dout;
  logic [31:0] ideximm;
  logic [31:0] idexpc4;
  logic [4:0]  idexrs;
  logic [4:0]  idexrt;
  logic [4:0]  idexwreg;

  logic        memwbregwrite;
  logic [4:0]  memwbwreg;
  logic [31:0] memwbdata;

  logic        stall;
  logic        flush;

  logic        exmbranch;
  logic        exmmemwrite;
  logic        exmregwrite;
  logic        exmmemtoreg;
  logic        exmbgtz;
  logic [31:0] exmaluresult;
  logic [31:0] exmr2_dout;
  logic [31:0] exmbtarget;
  logic [4:0]  exmwreg;
  logic        mulbusy;

  modport master (
    output idexaluop, idexalusrc, idexbranch, idexmemwrite, idexregwrite, idexmemtoreg,
    output idexr1_dout, idexr2_dout, ideximm, idexpc4, idexrs, idexrt, idexwreg,
    output memwbregwrite, memwbwreg, memwbdata, stall, flush,
    input  exmbranch, exmmemwrite, exmregwrite, exmmemtoreg, exmbgtz,
    input  exmaluresult, exmr2_dout, exmbtarget, exmwreg, mulbusy
  );

  modport slave (
    input  idexaluop, idexalusrc, idexbranch, idexmemwrite, idexregwrite, idexmemtoreg,
    input  idexr1_dout, idexr2_dout, ideximm, idexpc4, idexrs, idexrt, idexwreg,
    input  memwbregwrite, memwbwreg, memwbdata, stall, flush,
    output exmbranch, exmmemwrite, exmregwrite, exmmemtoreg, exmbgtz,
    output exmaluresult, exmr2_dout, exmbtarget, exmwreg, mulbusy
  );
endinterface

// File: rtl/uexe.sv
// MIPS execute stage with EX/MEM register: forwarding, ALU, branch target/bgtz evaluation
// and an iterative shift-add multiplier that stalls the front of the pipe while it runs.
module uexe #(
  parameter int unsigned MUL_CYCLES = 32
) (
  input logic   clk,
  input logic   rst,
  uexe_if.slave bus
);
  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_LUI = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  logic [31:0] fwd_a, fwd_rt, opnd_b, alu_res, btarget;
  logic [4:0]  shamt;
  logic        bgtz, mul_busy;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;

  logic        exm_branch_q, exm_branch_d;
  logic        exm_memwrite_q, exm_memwrite_d;
  logic        exm_regwrite_q, exm_regwrite_d;
  logic        exm_memtoreg_q, exm_memtoreg_d;
  logic        exm_bgtz_q, exm_bgtz_d;
  logic [31:0] exm_aluresult_q, exm_aluresult_d;
  logic [31:0] exm_r2_dout_q, exm_r2_dout_d;
  logic [31:0] exm_btarget_q, exm_btarget_d;
  logic [4:0]  exm_wreg_q, exm_wreg_d;

  // Loads are not forwarded from EX/MEM: their data does not exist until the memory stage.
  always_comb begin
    fwd_a = bus.idexr1_dout;
    if (exm_regwrite_q && exm_wreg_q != 5'd0 && exm_wreg_q == bus.idexrs && !exm_memtoreg_q) begin
      fwd_a = exm_aluresult_q;
    end else if (bus.memwbregwrite && bus.memwbwreg != 5'd0 && bus.memwbwreg == bus.idexrs) begin
      fwd_a = bus.memwbdata;
    end
  end

  always_comb begin
    fwd_rt = bus.idexr2_dout;
    if (exm_regwrite_q && exm_wreg_q != 5'd0 && exm_wreg_q == bus.idexrt && !exm_memtoreg_q) begin
      fwd_rt = exm_aluresult_q;
    end else if (bus.memwbregwrite && bus.memwbwreg != 5'd0 && bus.memwbwreg == bus.idexrt) begin
      fwd_rt = bus.memwbdata;
    end
  end

  assign opnd_b  = bus.idexalusrc ? bus.ideximm : fwd_rt;
  assign shamt   = bus.ideximm[10:6];
  assign btarget = bus.idexpc4 + {bus.ideximm[29:0], 2'b00};
  assign bgtz    = $signed(fwd_a) > 32'sd0;

  always_comb begin
    alu_res = 32'd0;
    case (bus.idexaluop)
      OP_ADD:  alu_res = fwd_a + opnd_b;
      OP_SUB:  alu_res = fwd_a - opnd_b;
      OP_AND:  alu_res = fwd_a & opnd_b;
      OP_OR:   alu_res = fwd_a | opnd_b;
      OP_XOR:  alu_res = fwd_a ^ opnd_b;
      OP_NOR:  alu_res = ~(fwd_a | opnd_b);
      OP_SLT:  alu_res = {31'd0, $signed(fwd_a) < $signed(opnd_b)};
      OP_SLL:  alu_res = opnd_b << shamt;
      OP_SRL:  alu_res = opnd_b >> shamt;
      OP_LUI:  alu_res = {bus.ideximm[15:0], 16'h0000};
      OP_MUL:  alu_res = acc_q;  // only reaches EX/MEM in DONE; every other cycle is a bubble
      default: alu_res = 32'd0;
    endcase
  end

  assign mul_busy = !rst && !bus.flush &&
                    (state_q == ST_RUN || (state_q == ST_IDLE && bus.idexaluop == OP_MUL));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (!bus.stall) begin
      if (bus.flush) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        acc_d   = 32'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.idexaluop == OP_MUL) begin
              mcand_d  = fwd_a;
              mplier_d = opnd_b;
              acc_d    = 32'd0;
              cnt_d    = '0;
              state_d  = ST_RUN;
            end
          end
          ST_RUN: begin
            if (mplier_q[0]) begin
              acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              state_d = ST_DONE;
            end
          end
          ST_DONE: state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    exm_branch_d    = exm_branch_q;
    exm_memwrite_d  = exm_memwrite_q;
    exm_regwrite_d  = exm_regwrite_q;
    exm_memtoreg_d  = exm_memtoreg_q;
    exm_bgtz_d      = exm_bgtz_q;
    exm_aluresult_d = exm_aluresult_q;
    exm_r2_dout_d   = exm_r2_dout_q;
    exm_btarget_d   = exm_btarget_q;
    exm_wreg_d      = exm_wreg_q;
    if (!bus.stall) begin
      if (bus.flush || mul_busy) begin
        exm_branch_d    = 1'b0;
        exm_memwrite_d  = 1'b0;
        exm_regwrite_d  = 1'b0;
        exm_memtoreg_d  = 1'b0;
        exm_bgtz_d      = 1'b0;
        exm_aluresult_d = 32'd0;
        exm_r2_dout_d   = 32'd0;
        exm_btarget_d   = 32'd0;
        exm_wreg_d      = 5'd0;
      end else begin
        exm_branch_d    = bus.idexbranch;
        exm_memwrite_d  = bus.idexmemwrite;
        exm_regwrite_d  = bus.idexregwrite;
        exm_memtoreg_d  = bus.idexmemtoreg;
        exm_bgtz_d      = bgtz;
        exm_aluresult_d = alu_res;
        exm_r2_dout_d   = fwd_rt;
        exm_btarget_d   = btarget;
        exm_wreg_d      = bus.idexwreg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      mcand_q         <= 32'd0;
      mplier_q        <= 32'd0;
      acc_q           <= 32'd0;
      exm_branch_q    <= 1'b0;
      exm_memwrite_q  <= 1'b0;
      exm_regwrite_q  <= 1'b0;
      exm_memtoreg_q  <= 1'b0;
      exm_bgtz_q      <= 1'b0;
      exm_aluresult_q <= 32'd0;
      exm_r2_dout_q   <= 32'd0;
      exm_btarget_q   <= 32'd0;
      exm_wreg_q      <= 5'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      mcand_q         <= mcand_d;
      mplier_q        <= mplier_d;
      acc_q           <= acc_d;
      exm_branch_q    <= exm_branch_d;
      exm_memwrite_q  <= exm_memwrite_d;
      exm_regwrite_q  <= exm_regwrite_d;
      exm_memtoreg_q  <= exm_memtoreg_d;
      exm_bgtz_q      <= exm_bgtz_d;
      exm_aluresult_q <= exm_aluresult_d;
      exm_r2_dout_q   <= exm_r2_dout_d;
      exm_btarget_q   <= exm_btarget_d;
      exm_wreg_q      <= exm_wreg_d;
    end
  end

  assign bus.exmbranch    = exm_branch_q;
  assign bus.exmmemwrite  = exm_memwrite_q;
  assign bus.exmregwrite  = exm_regwrite_q;
  assign bus.exmmemtoreg  = exm_memtoreg_q;
  assign bus.exmbgtz      = exm_bgtz_q;
  assign bus.exmaluresult = exm_aluresult_q;
  assign bus.exmr2_dout   = exm_r2_dout_q;
  assign bus.exmbtarget   = exm_btarget_q;
  assign bus.exmwreg      = exm_wreg_q;
  assign bus.mulbusy      = mul_busy;
endmodule
